// File: rtl/de_pipe_reg_pkg.sv
// -----------------------------------------------------------------------------
// de_pipe_reg_pkg
//   Shared definitions for the D-to-E pipeline register and its stall detector:
//   opcode/funct constants used by the decoder, Tuse/Tnew encodings, the nop
//   word, the default reset PC, the E-stage payload record and field helpers.
// -----------------------------------------------------------------------------
package de_pipe_reg_pkg;

   // Primary opcodes (Instr[31:26])
   localparam logic [5:0] OP_SPECIAL = 6'b000000;
   localparam logic [5:0] OP_BEQ     = 6'b000100;
   localparam logic [5:0] OP_ORI     = 6'b001101;
   localparam logic [5:0] OP_LUI     = 6'b001111;
   localparam logic [5:0] OP_LW      = 6'b100011;
   localparam logic [5:0] OP_SW      = 6'b101011;
   localparam logic [5:0] OP_JAL     = 6'b000011;

   // Function codes for OP_SPECIAL (Instr[5:0])
   localparam logic [5:0] FN_ADD     = 6'b100000;
   localparam logic [5:0] FN_ADDU    = 6'b100001;
   localparam logic [5:0] FN_SUBU    = 6'b100011;
   localparam logic [5:0] FN_JR      = 6'b001000;

   // Tuse value meaning "operand not read by this instruction"
   localparam logic [1:0] T_USE_NONE = 2'd3;

   // Bubble instruction word (sll $0,$0,0)
   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

   // Default PC loaded on reset and on bubble insertion
   localparam logic [31:0] RESET_PC  = 32'h0000_3000;

   // Index of each of the four hazard checks in the hit vector
   typedef enum logic [1:0] {
      HZ_RS_E = 2'd0,
      HZ_RT_E = 2'd1,
      HZ_RS_M = 2'd2,
      HZ_RT_M = 2'd3
   } hz_idx_e;

   localparam int unsigned HZ_COUNT = 4;

   // Payload carried from D into E
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] ext;
   } payload_t;

   function automatic logic [4:0] instr_rs(input logic [31:0] instr);
      return instr[25:21];
   endfunction

   function automatic logic [4:0] instr_rt(input logic [31:0] instr);
      return instr[20:16];
   endfunction

endpackage

// File: rtl/de_pipe_reg_hazard_cmp.sv
// -----------------------------------------------------------------------------
// hazard_cmp
//   One source-register x one pipeline-stage Tuse/Tnew hazard check.
//   Ports:
//     addr_i     source register read by the D-stage instruction
//     tuse_i     cycles until D needs that source (3 = not used)
//     wreg_i     destination register of the older instruction
//     regwrite_i write enable of the older instruction
//     tnew_i     cycles until the older instruction's result is available
//     hit_o      high when the dependency cannot be resolved by forwarding
// -----------------------------------------------------------------------------
module hazard_cmp
   import de_pipe_reg_pkg::*;
(
   input  logic [4:0] addr_i,
   input  logic [1:0] tuse_i,
   input  logic [4:0] wreg_i,
   input  logic       regwrite_i,
   input  logic [1:0] tnew_i,
   output logic       hit_o
);

   logic addr_match;
   logic too_early;

   // $0 is hard-wired; a write to it never produces a real dependency.
   assign addr_match = regwrite_i && (addr_i == wreg_i) && (addr_i != 5'd0);

   // Tnew never exceeds 2, so T_USE_NONE can never satisfy this.
   assign too_early  = (tuse_i < tnew_i);

   assign hit_o = addr_match && too_early;

endmodule

// File: rtl/de_pipe_reg.sv
// -----------------------------------------------------------------------------
// de_pipe_reg
//   D-to-E pipeline register with the pipeline stall detector. Each cycle the
//   D payload moves into E, or a bubble (nop, PC = RESET_PC) is inserted when a
//   Tuse/Tnew hazard against E or M cannot be forwarded. Also keeps a count of
//   stall cycles since reset.
//   Parameters:
//     RESET_PC   PC_E value on reset and bubble
//     CNT_W      implemented width of the stall counter (1..32); the counter
//                wraps at 2^CNT_W and is zero-extended onto stall_cnt
//   Ports:
//     clk, reset                   clock, asynchronous active-high reset
//     Instr_D, PC_D, RD1_D, RD2_D, Ext_D   D-stage payload
//     Tuse_rs, Tuse_rt             D-stage operand use times
//     WriteReg_E/RegWrite_E/T_new_E  destination info of the E instruction
//     WriteReg_M/RegWrite_M/T_new_M  destination info of the M instruction
//     stall                        combinational freeze for PC and F/D
//     Instr_E, PC_E, RD1_E, RD2_E, Ext_E  registered E-stage payload
//     stall_cnt                    stall cycles since reset
// -----------------------------------------------------------------------------
module de_pipe_reg #(
   parameter logic [31:0]  RESET_PC = de_pipe_reg_pkg::RESET_PC,
   parameter int unsigned  CNT_W    = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] Instr_D,
   input  logic [31:0] PC_D,
   input  logic [31:0] RD1_D,
   input  logic [31:0] RD2_D,
   input  logic [31:0] Ext_D,
   input  logic [1:0]  Tuse_rs,
   input  logic [1:0]  Tuse_rt,
   input  logic [4:0]  WriteReg_E,
   input  logic        RegWrite_E,
   input  logic [1:0]  T_new_E,
   input  logic [4:0]  WriteReg_M,
   input  logic        RegWrite_M,
   input  logic [1:0]  T_new_M,
   output logic        stall,
   output logic [31:0] Instr_E,
   output logic [31:0] PC_E,
   output logic [31:0] RD1_E,
   output logic [31:0] RD2_E,
   output logic [31:0] Ext_E,
   output logic [31:0] stall_cnt
);

   import de_pipe_reg_pkg::*;

   logic [4:0]          rs;
   logic [4:0]          rt;
   logic [HZ_COUNT-1:0] hit;

   payload_t            pay_d;
   payload_t            pay_q;
   payload_t            d_in;
   payload_t            bubble;

   logic [CNT_W-1:0]    cnt_d;
   logic [CNT_W-1:0]    cnt_q;

   assign rs = instr_rs(Instr_D);
   assign rt = instr_rt(Instr_D);

   // ---------------------------------------------------------------------
   // Hazard checks: {rs, rt} x {E, M}
   // ---------------------------------------------------------------------
   hazard_cmp u_hz_rs_e (
      .addr_i     (rs),
      .tuse_i     (Tuse_rs),
      .wreg_i     (WriteReg_E),
      .regwrite_i (RegWrite_E),
      .tnew_i     (T_new_E),
      .hit_o      (hit[HZ_RS_E])
   );

   hazard_cmp u_hz_rt_e (
      .addr_i     (rt),
      .tuse_i     (Tuse_rt),
      .wreg_i     (WriteReg_E),
      .regwrite_i (RegWrite_E),
      .tnew_i     (T_new_E),
      .hit_o      (hit[HZ_RT_E])
   );

   hazard_cmp u_hz_rs_m (
      .addr_i     (rs),
      .tuse_i     (Tuse_rs),
      .wreg_i     (WriteReg_M),
      .regwrite_i (RegWrite_M),
      .tnew_i     (T_new_M),
      .hit_o      (hit[HZ_RS_M])
   );

   hazard_cmp u_hz_rt_m (
      .addr_i     (rt),
      .tuse_i     (Tuse_rt),
      .wreg_i     (WriteReg_M),
      .regwrite_i (RegWrite_M),
      .tnew_i     (T_new_M),
      .hit_o      (hit[HZ_RT_M])
   );

   // Any number of simultaneous hits is still one stall cycle.
   assign stall = |hit;

   // ---------------------------------------------------------------------
   // Next-state for the E payload and the stall counter
   // ---------------------------------------------------------------------
   always_comb begin
      d_in       = '0;
      d_in.instr = Instr_D;
      d_in.pc    = PC_D;
      d_in.rd1   = RD1_D;
      d_in.rd2   = RD2_D;
      d_in.ext   = Ext_D;

      bubble       = '0;
      bubble.instr = NOP_INSTR;
      bubble.pc    = RESET_PC;

      pay_d = stall ? bubble : d_in;
   end

   // Natural modulo-2^CNT_W wrap, no overflow flag.
   always_comb begin
      cnt_d = cnt_q;
      if (stall) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pay_q       <= '0;
         pay_q.instr <= NOP_INSTR;
         pay_q.pc    <= RESET_PC;
         cnt_q       <= '0;
      end else begin
         pay_q <= pay_d;
         cnt_q <= cnt_d;
      end
   end

   assign Instr_E   = pay_q.instr;
   assign PC_E      = pay_q.pc;
   assign RD1_E     = pay_q.rd1;
   assign RD2_E     = pay_q.rd2;
   assign Ext_E     = pay_q.ext;
   assign stall_cnt = 32'(cnt_q);

endmodule
